// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential sign-magnitude neuron:
// FSM state encoding, accumulator sizing, sign conversion and saturation limit.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FINAL,
    DONE
  } state_t;

  function automatic int acc_width(input int num_inputs, input int data_w);
    return 2 * (data_w - 1) + $clog2(num_inputs) + 1;
  endfunction

  // Callers size-cast the result down to their own product width.
  function automatic logic [63:0] sm_to_tc(input logic neg, input logic [63:0] mag);
    return neg ? (~mag + 64'd1) : mag;
  endfunction

  function automatic int sat_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sm_mult.sv
// Combinational sign-magnitude multiplier returning a two's-complement product.
// Negative zero (zero magnitude with sign set) collapses to plain zero.
module sm_mult
  import neuron_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]       a,
  input  logic [DATA_W-1:0]       w,
  output logic [2*(DATA_W-1):0]   product
);

  localparam int MAG_W = 2 * (DATA_W - 1);

  logic [MAG_W-1:0] mag;
  logic             neg;

  always_comb begin
    mag     = MAG_W'(a[DATA_W-2:0]) * MAG_W'(w[DATA_W-2:0]);
    neg     = (a[DATA_W-1] ^ w[DATA_W-1]) && (mag != '0);
    product = (MAG_W + 1)'(sm_to_tc(neg, 64'(mag)));
  end

endmodule

// File: rtl/neuron_seq_mac.sv
// Sequential neuron: one sign-magnitude product per cycle, then rescale and saturate.
// Define NEURON_RELU_EN to clamp negative results to zero.
module neuron_seq_mac
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_W     = 8,
  parameter int FRAC_BITS  = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_INPUTS*DATA_W-1:0] inputs,
  input  logic [NUM_INPUTS*DATA_W-1:0] weights,
  input  logic                         start_signal,
  output logic [DATA_W-1:0]            out,
  output logic                         ready_signal
);

  localparam int ACC_W  = acc_width(NUM_INPUTS, DATA_W);
  localparam int PROD_W = 2 * (DATA_W - 1) + 1;
  localparam int IDX_W  = $clog2(NUM_INPUTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS);
  localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'(sat_max(DATA_W));

  state_t state, next_state;
  logic   load, mac_step, finish;

  logic [NUM_INPUTS*DATA_W-1:0] in_reg, w_reg;
  logic [IDX_W-1:0]             idx, sel;
  logic [DATA_W-1:0]            a_sel, w_sel;
  logic [PROD_W-1:0]            prod, prod_reg;
  logic [ACC_W-1:0]             acc, acc_abs, shifted;
  logic                         acc_neg, res_neg;
  logic [DATA_W-2:0]            res_mag;
  logic [DATA_W-1:0]            result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    mac_step   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_signal) begin
          load       = 1'b1;
          next_state = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (idx == LAST_IDX) next_state = FINAL;
      end
      FINAL: begin
        finish     = 1'b1;
        next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Product is registered, so MAC runs one extra drain cycle to absorb the last term.
  always_comb begin
    sel   = (idx < LAST_IDX) ? idx : '0;
    a_sel = in_reg[sel*DATA_W +: DATA_W];
    w_sel = w_reg[sel*DATA_W +: DATA_W];
  end

  sm_mult #(.DATA_W(DATA_W)) u_mult (
    .a       (a_sel),
    .w       (w_sel),
    .product (prod)
  );

  always_comb begin
    acc_neg = acc[ACC_W-1];
    acc_abs = acc_neg ? (~acc + ACC_W'(1)) : acc;
    shifted = acc_abs >> FRAC_BITS;
    res_mag = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-2:0] : shifted[DATA_W-2:0];
    res_neg = acc_neg && (res_mag != '0);
`ifdef NEURON_RELU_EN
    result  = res_neg ? '0 : {1'b0, res_mag};
`else
    result  = {res_neg, res_mag};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg       <= '0;
      w_reg        <= '0;
      idx          <= '0;
      prod_reg     <= '0;
      acc          <= '0;
      out          <= '0;
      ready_signal <= 1'b0;
    end else begin
      if (load) begin
        in_reg       <= inputs;
        w_reg        <= weights;
        idx          <= '0;
        acc          <= '0;
        ready_signal <= 1'b0;
      end
      if (mac_step) begin
        prod_reg <= prod;
        idx      <= idx + IDX_W'(1);
        if (idx != '0) acc <= acc + {{(ACC_W - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
      end
      if (finish) begin
        out          <= result;
        ready_signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Scoreboard bench for neuron_seq_mac: default instance plus a 3x6-bit instance,
// checked against an integer reference model of the neuron arithmetic.
module tb_neuron_seq_mac;

  typedef struct {
    int val;
    int accept;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_a = '0, w_a = '0;
  logic [17:0] in_b = '0, w_b = '0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  out_a;
  logic [5:0]  out_b;
  logic        ready_a, ready_b;
  logic        prev_a = 1'b0, prev_b = 1'b0;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  neuron_seq_mac #(.NUM_INPUTS(8), .DATA_W(8), .FRAC_BITS(6)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .inputs       (in_a),
    .weights      (w_a),
    .start_signal (start_a),
    .out          (out_a),
    .ready_signal (ready_a)
  );

  neuron_seq_mac #(.NUM_INPUTS(3), .DATA_W(6), .FRAC_BITS(4)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .inputs       (in_b),
    .weights      (w_b),
    .start_signal (start_b),
    .out          (out_b),
    .ready_signal (ready_b)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Neuron arithmetic straight from the number format: signed integer sum, then rescale.
  function automatic int refModel(input logic [63:0] ins, input logic [63:0] ws,
                                  input int n, input int dw, input int fb);
    int sum = 0;
    int mag, ea, ew, ma, mw;
    logic [63:0] mask = (64'd1 << dw) - 64'd1;
    for (int i = 0; i < n; i++) begin
      ea = int'((ins >> (i * dw)) & mask);
      ew = int'((ws >> (i * dw)) & mask);
      ma = ea % (1 << (dw - 1));
      mw = ew % (1 << (dw - 1));
      if ((ea >= (1 << (dw - 1))) != (ew >= (1 << (dw - 1)))) sum -= ma * mw;
      else sum += ma * mw;
    end
    mag = ((sum < 0) ? -sum : sum) / (1 << fb);
    if (mag > (1 << (dw - 1)) - 1) mag = (1 << (dw - 1)) - 1;
    if (sum < 0 && mag != 0) begin
`ifdef NEURON_RELU_EN
      return 0;
`else
      return (1 << (dw - 1)) + mag;
`endif
    end
    return mag;
  endfunction

  task automatic applyStimulus(input int sel, input logic [63:0] ins, input logic [63:0] ws,
                               input int expv);
    exp_t e;
    @(negedge clk);
    if (sel == 0) begin
      in_a = ins; w_a = ws; start_a = 1'b1;
    end else begin
      in_b = ins[17:0]; w_b = ws[17:0]; start_b = 1'b1;
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    e.val    = expv;
    e.accept = cyc;
    if (sel == 0) begin
      qa.push_back(e);
      checkOutput("ready_drop_a", int'(ready_a), 0);
    end else begin
      qb.push_back(e);
      checkOutput("ready_drop_b", int'(ready_b), 0);
    end
  endtask

  task automatic waitDrain(input int sel);
    int budget = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && budget < 40) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (sel == 0 && qa.size() != 0) begin
      checkOutput("drain_timeout_a", qa.size(), 0);
      qa.delete();
    end
    if (sel == 1 && qb.size() != 0) begin
      checkOutput("drain_timeout_b", qb.size(), 0);
      qb.delete();
    end
  endtask

  // Monitors: every rising ready must match the oldest pending expectation and its latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready_a && !prev_a) begin
      if (qa.size() == 0) checkOutput("spurious_ready_a", 1, 0);
      else begin
        e = qa.pop_front();
        checkOutput("out_a", int'(out_a), e.val);
        checkOutput("latency_a", cyc - e.accept, 10);
      end
    end
    prev_a <= ready_a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready_b && !prev_b) begin
      if (qb.size() == 0) checkOutput("spurious_ready_b", 1, 0);
      else begin
        e = qb.pop_front();
        checkOutput("out_b", int'(out_b), e.val);
        checkOutput("latency_b", cyc - e.accept, 5);
      end
    end
    prev_b <= ready_b;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] ins, ws;
    int neg_exp;
`ifdef NEURON_RELU_EN
    neg_exp = 0;
`else
    neg_exp = 'hA0;
`endif
    #1;
    checkOutput("reset_out_a", int'(out_a), 0);
    checkOutput("reset_ready_a", int'(ready_a), 0);
    checkOutput("reset_out_b", int'(out_b), 0);
    checkOutput("reset_ready_b", int'(ready_b), 0);
    #12 rst_n = 1'b1;

    applyStimulus(0, 64'h40, 64'h20, 'h20);                           waitDrain(0);
    applyStimulus(0, 64'h40, 64'hA0, neg_exp);                        waitDrain(0);
    applyStimulus(0, {8{8'h40}}, {8{8'h40}}, 'h7F);                   waitDrain(0);
    applyStimulus(0, {8{8'h40}}, {4{8'hC0, 8'h40}}, 0);               waitDrain(0);

    // Negative-zero term, with a competing start pulse while the MAC loop runs.
    applyStimulus(0, 64'h80, 64'hFF, 0);
    repeat (2) @(negedge clk);
    in_a = {8{8'h40}};
    w_a = {8{8'h40}};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitDrain(0);
    repeat (12) @(negedge clk);

    // Reset in the middle of a computation while out still holds a saturated result.
    applyStimulus(0, {8{8'h40}}, {8{8'h40}}, 'h7F);                   waitDrain(0);
    applyStimulus(0, 64'h40, 64'h20, 'h20);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_a", int'(out_a), 0);
    checkOutput("midreset_ready_a", int'(ready_a), 0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 64'h40, 64'h20, 'h20);                           waitDrain(0);

    for (int i = 0; i < 40; i++) begin
      ins = {$urandom, $urandom};
      ws  = {$urandom, $urandom};
      if (i % 2 == 1) ws = ws & 64'h8F8F8F8F8F8F8F8F;
      applyStimulus(0, ins, ws, refModel(ins, ws, 8, 8, 6));
      waitDrain(0);
    end

    for (int i = 0; i < 500; i++) begin
      ins = 64'($urandom_range(0, 18'h3FFFF));
      ws  = 64'($urandom_range(0, 18'h3FFFF));
      if (i % 2 == 1) ws = ws & 64'h27_9E7;
      applyStimulus(1, ins, ws, refModel(ins, ws, 3, 6, 4));
      waitDrain(1);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_seq_mac.md
Name: neuron_seq_mac

Overview:
- Parametrised sequential neuron; successor to the fixed 8-input, 8-bit LUT neuron.
- Multiplies NUM_INPUTS sign-magnitude inputs by matching weights, one product per cycle.
- Rescales and saturates the sum, then returns a sign-magnitude result under a start/ready handshake.
- Sits in the layer datapath; one instance per neuron, driven by the layer controller.

Parameters:
- NUM_INPUTS, 8, operand pairs per neuron (>=2).
- DATA_W, 8, width of each operand and of the result; MSB is sign, the rest is magnitude.
- FRAC_BITS, 6, fractional bits of the fixed-point format; the product is shifted right by this amount.
- ACC_W (localparam), 2*(DATA_W-1)+clog2(NUM_INPUTS)+1, width of the two's-complement accumulator.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- inputs, input, NUM_INPUTS*DATA_W, packed operands; element i is at [i*DATA_W +: DATA_W].
- weights, input, NUM_INPUTS*DATA_W, packed weights, same packing as inputs.
- start_signal, input, 1, request to start; sampled on clk.
- out, output, DATA_W, sign-magnitude result.
- ready_signal, output, 1, result valid.

Behaviour:
- Reset: asynchronous, active-low, takes effect immediately, including mid-operation.
  - State goes to IDLE; out=0, ready_signal=0, accumulator=0, index=0.
  - Any computation in progress is discarded.
- States:
  - IDLE: start_signal=1 latches inputs and weights into internal registers, clears accumulator and index, then goes to MAC.
  - MAC: each cycle adds the signed product of element[index] to the accumulator and increments index; after element NUM_INPUTS-1, goes to FINAL.
  - FINAL: computes the result, registers out, sets ready_signal=1, goes to DONE.
  - DONE: holds out and ready_signal. start_signal=1 behaves as in IDLE, and ready_signal falls on that same edge.
- Latency: ready_signal rises exactly NUM_INPUTS+2 rising edges after the edge that accepts start_signal.
- Start handling: start_signal is ignored in MAC and FINAL; no queuing. Input buses may change freely after the accepting edge.
- Product arithmetic:
  - Magnitude = |a|*|w|, width 2*(DATA_W-1).
  - Sign = sa XOR sw, with sign forced to 0 when the magnitude is 0 (negative zero is treated as zero).
  - The product is converted to two's complement before accumulation.
  - ACC_W is wide enough that the accumulator never overflows.
- Finalise:
  - Split the accumulator into sign and absolute value.
  - Shift the absolute value right by FRAC_BITS (truncation toward zero, symmetric for both signs).
  - Saturate the magnitude at 2^(DATA_W-1)-1.
  - Output sign-magnitude; a zero magnitude always outputs sign 0.
- out changes only on the FINAL edge or on reset.

Optional Feature:
- NEURON_RELU_EN defined: in FINAL, any negative result is replaced by 0, so out is never negative.
- Undefined: signed result as described above.
- Latency is identical in both builds.

Decomposition:
- Package neuron_pkg holds:
  - state encoding constants (IDLE, MAC, FINAL, DONE);
  - a function computing the accumulator width;
  - the sign-magnitude to two's-complement conversion helper;
  - the saturation-maximum constant.
- Sub-module sm_mult: combinational sign-magnitude multiplier, DATA_W-parametrised, returning the two's-complement product. It is instantiated once and shared across cycles via the index mux.

Test Plan (default parameters unless stated):
- Single nonzero term: input0=0x40, weight0=0x20, all others 0; pulse start -> ready_signal high 10 edges later, out=0x20.
- Negative result: input0=0x40, weight0=0xA0, all others 0 -> out=0xA0. With NEURON_RELU_EN defined -> out=0x00.
- Saturation and cancellation:
  - All inputs 0x40, all weights 0x40 -> sum 32768, >>6 = 512 -> out=0x7F.
  - Repeat with weights alternating 0x40 and 0xC0 -> out=0x00.
- Negative zero and start during busy:
  - input0=0x80, weight0=0xFF, all others 0 -> out=0x00.
  - A second start pulse during MAC is ignored; ready_signal still rises on edge 10.
  - Back-to-back: start asserted while in DONE -> ready_signal drops on that edge; new result after 10 edges.
- Reset mid-operation: assert rst_n=0 after 4 MAC cycles -> out=0 and ready_signal=0 immediately. Release, restart with the first scenario's operands -> out=0x20 with nominal latency.
- Parameter sweep: NUM_INPUTS=3, DATA_W=6, FRAC_BITS=4, random operands over 500 runs -> out matches a bench reference model exactly; latency is 5 edges.
